// File: rtl/fetch_stage.sv
// Instruction fetch for the 16-bit RISC pipeline: PC, one/two-word instruction
// assembly and the IF/ID pipeline register presented to decode.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_data,
  input  logic              pc_write,
  input  logic              stall_fetch,
  input  logic              flush_fetch,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              ifid_valid,
  output logic [15:0]       ifid_instr,
  output logic [15:0]       ifid_imm,
  output logic              ifid_has_imm,
  output logic [ADDR_W-1:0] ifid_pc,
  output logic [ADDR_W-1:0] ifid_pc_next,
  output logic [2:0]        ifid_rdst,
  output logic [2:0]        ifid_rsrc
);

  typedef enum logic [0:0] {StOpc, StImm} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic              valid_q, valid_d;
  logic [15:0]       instr_q, instr_d;
  logic [15:0]       imm_q, imm_d;
  logic              has_imm_q, has_imm_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [ADDR_W-1:0] ipc_next_q, ipc_next_d;
  logic [ADDR_W-1:0] pc_inc;

  // Natural overflow of the ADDR_W-wide sum gives the modulo-2^ADDR_W wrap.
  assign pc_inc = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    has_imm_d    = has_imm_q;
    ipc_d        = ipc_q;
    ipc_next_d   = ipc_next_q;

    if (flush_fetch) begin
      valid_d      = 1'b0;
      instr_d      = '0;
      imm_d        = '0;
      has_imm_d    = 1'b0;
      state_d      = StOpc;
      hold_instr_d = '0;
      hold_pc_d    = '0;
      if (branch_taken) begin
        pc_d = branch_target;
      end
    end else if (!stall_fetch) begin
      if (!pc_write) begin
        valid_d   = 1'b0;
        instr_d   = '0;
        imm_d     = '0;
        has_imm_d = 1'b0;
      end else begin
        pc_d = pc_inc;
        unique case (state_q)
          StOpc: begin
            if (imem_data[15]) begin
              hold_instr_d = imem_data;
              hold_pc_d    = pc_q;
              state_d      = StImm;
              valid_d      = 1'b0;
              instr_d      = '0;
              imm_d        = '0;
              has_imm_d    = 1'b0;
            end else begin
              valid_d    = 1'b1;
              instr_d    = imem_data;
              imm_d      = '0;
              has_imm_d  = 1'b0;
              ipc_d      = pc_q;
              ipc_next_d = pc_inc;
            end
          end
          StImm: begin
            valid_d    = 1'b1;
            instr_d    = hold_instr_q;
            imm_d      = imem_data;
            has_imm_d  = 1'b1;
            ipc_d      = hold_pc_q;
            ipc_next_d = pc_inc;
            state_d    = StOpc;
          end
          default: state_d = StOpc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StOpc;
      pc_q         <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= '0;
      imm_q        <= '0;
      has_imm_q    <= 1'b0;
      ipc_q        <= '0;
      ipc_next_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      imm_q        <= imm_d;
      has_imm_q    <= has_imm_d;
      ipc_q        <= ipc_d;
      ipc_next_q   <= ipc_next_d;
    end
  end

  assign imem_addr    = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_instr   = instr_q;
  assign ifid_imm     = imm_q;
  assign ifid_has_imm = has_imm_q;
  assign ifid_pc      = ipc_q;
  assign ifid_pc_next = ipc_next_q;
  assign ifid_rdst    = instr_q[10:8];
  assign ifid_rsrc    = instr_q[7:5];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random control traffic, all
// checked against a transaction-level fetch model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] mem [256];

  // Instance A: RESET_PC = 0x00010, fully modelled.
  logic [19:0] a_addr, a_tgt, a_pc, a_pc_next;
  logic [15:0] a_data, a_instr, a_imm;
  logic        a_pcw, a_stall, a_flush, a_bt, a_valid, a_has_imm;
  logic [2:0]  a_rdst, a_rsrc;

  // Instance B: RESET_PC = 0xFFFFF, wrap-around checks.
  logic [19:0] b_addr, b_pc, b_pc_next;
  logic [15:0] b_data, b_instr, b_imm;
  logic        b_pcw, b_valid, b_has_imm;
  logic [2:0]  b_rdst, b_rsrc;
  logic        zero1;
  logic [19:0] zero20;

  int total = 0;
  int bad   = 0;

  // Reference model state for instance A
  logic [19:0] m_pc, m_hpc, m_ipc, m_inext;
  logic        m_pend, m_v, m_hi;
  logic [15:0] m_hw, m_i, m_imm;

  assign a_data = mem[a_addr[7:0]];
  assign b_data = mem[b_addr[7:0]];
  assign zero1  = 1'b0;
  assign zero20 = '0;

  fetch_stage #(.ADDR_W(20), .RESET_PC(20'h00010)) u_a (
    .clk(clk), .rst(rst), .imem_addr(a_addr), .imem_data(a_data),
    .pc_write(a_pcw), .stall_fetch(a_stall), .flush_fetch(a_flush),
    .branch_taken(a_bt), .branch_target(a_tgt), .ifid_valid(a_valid),
    .ifid_instr(a_instr), .ifid_imm(a_imm), .ifid_has_imm(a_has_imm),
    .ifid_pc(a_pc), .ifid_pc_next(a_pc_next), .ifid_rdst(a_rdst), .ifid_rsrc(a_rsrc)
  );

  fetch_stage #(.ADDR_W(20), .RESET_PC(20'hFFFFF)) u_b (
    .clk(clk), .rst(rst), .imem_addr(b_addr), .imem_data(b_data),
    .pc_write(b_pcw), .stall_fetch(zero1), .flush_fetch(zero1),
    .branch_taken(zero1), .branch_target(zero20), .ifid_valid(b_valid),
    .ifid_instr(b_instr), .ifid_imm(b_imm), .ifid_has_imm(b_has_imm),
    .ifid_pc(b_pc), .ifid_pc_next(b_pc_next), .ifid_rdst(b_rdst), .ifid_rsrc(b_rsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_bubble();
    m_v = 1'b0; m_i = '0; m_imm = '0; m_hi = 1'b0;
  endtask

  // One clock of fetch behaviour, evaluated from the sampled inputs.
  task automatic model_step();
    logic [15:0] w;
    w = mem[m_pc[7:0]];
    if (rst) begin
      m_pc = 20'h00010; m_pend = 1'b0; m_hw = '0; m_hpc = '0;
      set_bubble(); m_ipc = '0; m_inext = '0;
    end else if (a_flush) begin
      set_bubble();
      m_pend = 1'b0; m_hw = '0; m_hpc = '0;
      if (a_bt) m_pc = a_tgt;
    end else if (a_stall) begin
      // everything holds
    end else if (!a_pcw) begin
      set_bubble();
    end else if (m_pend) begin
      m_v = 1'b1; m_i = m_hw; m_imm = w; m_hi = 1'b1;
      m_ipc = m_hpc; m_inext = m_pc + 20'd1;
      m_pend = 1'b0; m_pc = m_pc + 20'd1;
    end else if (w[15]) begin
      set_bubble();
      m_pend = 1'b1; m_hw = w; m_hpc = m_pc; m_pc = m_pc + 20'd1;
    end else begin
      m_v = 1'b1; m_i = w; m_imm = '0; m_hi = 1'b0;
      m_ipc = m_pc; m_inext = m_pc + 20'd1; m_pc = m_pc + 20'd1;
    end
  endtask

  task automatic cmp_a(input string tag);
    check({tag, ".addr"},    a_addr,    m_pc);
    check({tag, ".valid"},   a_valid,   m_v);
    check({tag, ".instr"},   a_instr,   m_i);
    check({tag, ".imm"},     a_imm,     m_imm);
    check({tag, ".has_imm"}, a_has_imm, m_hi);
    check({tag, ".pc"},      a_pc,      m_ipc);
    check({tag, ".pc_next"}, a_pc_next, m_inext);
    check({tag, ".rdst"},    a_rdst,    {29'd0, m_i[10:8]});
    check({tag, ".rsrc"},    a_rsrc,    {29'd0, m_i[7:5]});
  endtask

  // Drive at negedge, advance one edge, compare at the following negedge.
  task automatic step(input string tag, input logic s, input logic f, input logic b,
                      input logic [19:0] t, input logic w);
    a_stall = s; a_flush = f; a_bt = b; a_tgt = t; a_pcw = w;
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_a(tag);
  endtask

  initial begin
    rst = 1'b1; a_stall = 0; a_flush = 0; a_bt = 0; a_tgt = '0; a_pcw = 1; b_pcw = 1;
    m_pc = '0; m_hpc = '0; m_ipc = '0; m_inext = '0; m_pend = 0; m_v = 0; m_hi = 0;
    m_hw = '0; m_i = '0; m_imm = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h10] = 16'h0123; mem[8'h11] = 16'h0456;
    mem[8'h20] = 16'h8A40; mem[8'h21] = 16'hBEEF;
    mem[8'h22] = 16'h9111; mem[8'h23] = 16'h7777;
    mem[8'h24] = 16'h8222; mem[8'h25] = 16'h1234;
    mem[8'h40] = 16'h0345; mem[8'hFF] = 16'h0567;
    @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      step("reset", 0, 0, 0, '0, 1);
      check("reset.addr_const", a_addr, 32'h10);
      check("reset.valid_const", a_valid, 0);
      check("reset.b_addr", b_addr, 32'hFFFFF);
    end
    rst = 1'b0;

    step("w1", 0, 0, 0, '0, 1);
    check("w1.instr", a_instr, 32'h0123);
    check("w1.pc_next", a_pc_next, 32'h11);
    check("w1.rdst", a_rdst, 1);
    check("w1.rsrc", a_rsrc, 1);
    step("w2", 0, 0, 0, '0, 1);
    check("w2.instr", a_instr, 32'h0456);
    check("w2.pc", a_pc, 32'h11);
    check("w2.pc_next", a_pc_next, 32'h12);
    for (int i = 0; i < 14; i++) step("nop", 0, 0, 0, '0, 1);

    step("two.bubble", 0, 0, 0, '0, 1);
    check("two.bubble_valid", a_valid, 0);
    step("two", 0, 0, 0, '0, 1);
    check("two.instr", a_instr, 32'h8A40);
    check("two.imm", a_imm, 32'hBEEF);
    check("two.has_imm", a_has_imm, 1);
    check("two.pc", a_pc, 32'h20);
    check("two.pc_next", a_pc_next, 32'h22);

    step("stl.opc", 0, 0, 0, '0, 1);
    for (int i = 0; i < 2; i++) begin
      step("stl.hold", 1, 0, 0, '0, 0);
      check("stl.addr", a_addr, 32'h23);
      check("stl.valid", a_valid, 0);
    end
    step("stl.rel", 0, 0, 0, '0, 1);
    check("stl.instr", a_instr, 32'h9111);
    check("stl.imm", a_imm, 32'h7777);

    step("fl.opc", 0, 0, 0, '0, 1);
    step("fl.flush", 1, 1, 1, 20'h40, 1);
    check("fl.addr", a_addr, 32'h40);
    check("fl.valid", a_valid, 0);
    step("fl.next", 0, 0, 0, '0, 1);
    check("fl.instr", a_instr, 32'h0345);
    check("fl.has_imm", a_has_imm, 0);

    // Wrap-around on instance B
    rst = 1'b1;
    step("wrap.rst", 0, 0, 0, '0, 1);
    rst = 1'b0;
    b_pcw = 1'b0;
    step("wrap.a0", 0, 0, 0, '0, 1);
    check("wrap.pcw0_valid", b_valid, 0);
    check("wrap.pcw0_instr", b_instr, 0);
    check("wrap.pcw0_addr", b_addr, 32'hFFFFF);
    b_pcw = 1'b1;
    step("wrap.a1", 0, 0, 0, '0, 1);
    check("wrap.valid", b_valid, 1);
    check("wrap.instr", b_instr, 32'h0567);
    check("wrap.pc", b_pc, 32'hFFFFF);
    check("wrap.pc_next", b_pc_next, 32'h00000);
    check("wrap.addr", b_addr, 32'h00000);

    // Random program and random hazard-controller traffic
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 800; n++) begin
      logic [19:0] t;
      t = {12'h000, 8'($urandom)};
      if ($urandom_range(0, 3) == 0) t[19:8] = 12'hFFF;
      rst = ($urandom_range(0, 99) < 2);
      step("rand", $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
           1'($urandom), t, $urandom_range(0, 99) < 85);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
PC register, instruction-fetch sequencer and IF/ID pipeline register for the 16-bit RISC pipeline. It reads the instruction memory one 16-bit word per cycle, assembles two-word instructions (opcode word followed by an immediate word), and presents completed instructions to decode. It consumes stall_fetch, flush_fetch and pc_write from the hazard controller. It exports the register fields of the instruction in IF/ID, which the hazard controller uses as R_src_fetch and R_dest_fetch.

Parameters:
ADDR_W, 20, instruction address width in words.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset; synchronous, active-high.
imem_addr  out  ADDR_W  instruction memory word address; equals pc, combinational.
imem_data  in  16  instruction memory read data for imem_addr, same cycle (asynchronous read).
pc_write  in  1  0 = hold pc this cycle.
stall_fetch  in  1  1 = freeze pc, FSM and IF/ID.
flush_fetch  in  1  1 = squash the in-flight fetch and IF/ID contents.
branch_taken  in  1  qualifies branch_target; used only with flush_fetch.
branch_target  in  ADDR_W  redirect address.
ifid_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
ifid_instr  out  16  opcode word.
ifid_imm  out  16  immediate word; 0 for one-word instructions.
ifid_has_imm  out  1  instruction was two words.
ifid_pc  out  ADDR_W  address of the opcode word.
ifid_pc_next  out  ADDR_W  address following the full instruction (return address).
ifid_rdst  out  3  ifid_instr[10:8], combinational.
ifid_rsrc  out  3  ifid_instr[7:5], combinational.

Behaviour:
- Encoding: imem_data[15] = 1 marks an opcode word followed by an immediate word. Immediate words are never decoded for bit 15.
- FSM states: OPC (fetching an opcode word) and IMM (fetching an immediate word). An internal hold register keeps the pending opcode word and its address.
- Reset (rst = 1 at an edge, overriding everything):
  - pc = RESET_PC, state = OPC, hold cleared.
  - ifid_valid = 0, ifid_instr = 0, ifid_imm = 0, ifid_has_imm = 0, ifid_pc = 0, ifid_pc_next = 0.
- Priority per edge: rst > flush_fetch > stall_fetch > pc_write = 0 > normal.
- flush_fetch = 1:
  - IF/ID becomes a bubble: valid = 0, instr/imm/has_imm = 0; ifid_pc and ifid_pc_next unchanged.
  - state = OPC and the hold register is discarded, including a half-assembled two-word instruction.
  - pc = branch_target if branch_taken = 1, otherwise pc holds.
  - flush overrides a simultaneous stall.
- stall_fetch = 1 (no flush): pc, state, hold register and all IF/ID outputs hold their values exactly; pc_write is ignored.
- pc_write = 0 (no flush, no stall): pc and state hold; IF/ID loads a bubble (valid = 0, instr = 0).
- Normal, state OPC:
  - If imem_data[15] = 0: IF/ID loads valid = 1, instr = imem_data, imm = 0, has_imm = 0, pc = pc, pc_next = pc+1. Then pc = pc+1.
  - If imem_data[15] = 1: hold = {imem_data, pc}; IF/ID loads a bubble; pc = pc+1; state = IMM.
- Normal, state IMM: IF/ID loads valid = 1, instr = hold word, imm = imem_data, has_imm = 1, ifid_pc = held address, pc_next = pc+1. Then pc = pc+1 and state = OPC.
- Latency: a one-word instruction reaches IF/ID 1 cycle after its address is presented; a two-word instruction reaches IF/ID 2 cycles after its opcode address. A two-word instruction costs one bubble.
- All PC arithmetic is modulo 2^ADDR_W: pc = 2^ADDR_W-1 wraps to 0, and ifid_pc_next wraps the same way.
- ifid_rdst and ifid_rsrc are pure field slices of ifid_instr; a bubble therefore yields 0/0.

Test Plan:
- Reset with RESET_PC = 0x00010 -> imem_addr = 0x00010, ifid_valid = 0, all IF/ID outputs 0; held across 3 reset cycles.
- Words 0x0123, 0x0456 at 0x10, 0x11 -> next two cycles ifid_instr = 0x0123 (pc 0x10, pc_next 0x11) then 0x0456 (pc 0x11, pc_next 0x12), valid = 1 both; ifid_rdst = 1, ifid_rsrc = 1 for 0x0123.
- Two-word instruction 0x8A40, immediate 0xBEEF at 0x20 -> one bubble, then valid = 1, instr = 0x8A40, imm = 0xBEEF, has_imm = 1, pc = 0x20, pc_next = 0x22.
- stall_fetch = 1 for 2 cycles while in IMM -> imem_addr and all IF/ID outputs frozen; after release the assembled instruction appears with the correct immediate.
- flush_fetch = 1, branch_taken = 1, branch_target = 0x40 while in IMM, with stall_fetch = 1 in the same cycle -> next cycle imem_addr = 0x40, ifid_valid = 0, state OPC; the half-fetched instruction never appears.
- RESET_PC = 0xFFFFF with a one-word instruction there -> ifid_pc_next = 0x00000 and imem_addr = 0x00000; with pc_write = 0 for 1 cycle instead -> one bubble and imem_addr stays 0xFFFFF.
